decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 55 +++++
 rtl/fwd_select.sv | 43 ++++
 rtl/decode_stage.sv | 173 +++++++++++++++++
 tb/tb_decode_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared encodings, widths and register layouts for the decode stage
package decode_stage_pkg;

    localparam int WORD = 32;
    localparam int BYTE = 8;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] NOREG = 4'hF;
    localparam logic [3:0] ESP   = 4'h4;

    typedef struct packed {
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [3:0]      ra;
        logic [3:0]      rb;
        logic [WORD-1:0] valc;
        logic [WORD-1:0] valp;
    } d_reg_t;

    typedef struct packed {
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [WORD-1:0] valc;
        logic [WORD-1:0] vala;
        logic [WORD-1:0] valb;
        logic [3:0]      dste;
        logic [3:0]      dstm;
        logic [3:0]      srca;
        logic [3:0]      srcb;
    } e_reg_t;

    localparam d_reg_t D_BUBBLE = '{icode: I_NOP, ifun: 4'h0, ra: NOREG, rb: NOREG,
                                    valc: '0, valp: '0};

    localparam e_reg_t E_BUBBLE = '{icode: I_NOP, ifun: 4'h0, valc: '0, vala: '0, valb: '0,
                                    dste: NOREG, dstm: NOREG, srca: NOREG, srcb: NOREG};

    // CALL pushes and JXX carries the fall-through PC, both through valA
    function automatic logic uses_valp(input logic [3:0] icode);
        return (icode == I_CALL) || (icode == I_JXX);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - operand forwarding selector for one register-file read port
module fwd_select
    import decode_stage_pkg::*;
(
    input  logic [3:0]      src,
    input  logic            use_valp,
    input  logic [WORD-1:0] valp,
    input  logic [3:0]      e_dstE,
    input  logic [WORD-1:0] e_valE,
    input  logic [3:0]      M_dstM,
    input  logic [WORD-1:0] m_valM,
    input  logic [3:0]      M_dstE,
    input  logic [WORD-1:0] M_valE,
    input  logic [3:0]      W_dstM,
    input  logic [WORD-1:0] W_valM,
    input  logic [3:0]      W_dstE,
    input  logic [WORD-1:0] W_valE,
    input  logic [WORD-1:0] rf_val,
    output logic [WORD-1:0] val
);

    // Youngest producer wins; a NOREG source never reads or matches anything
    always_comb begin
        val = '0;
        if (use_valp) begin
            val = valp;
        end else if (src != NOREG) begin
            if (src == e_dstE)
                val = e_valE;
            else if (src == M_dstM)
                val = m_valM;
            else if (src == M_dstE)
                val = M_valE;
            else if (src == W_dstM)
                val = W_valM;
            else if (src == W_dstE)
                val = W_valE;
            else
                val = rf_val;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - pipeline decode stage: D register, operand decode/forwarding, E register
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      f_icode,
    input  logic [3:0]      f_ifun,
    input  logic [3:0]      f_rA,
    input  logic [3:0]      f_rB,
    input  logic [WORD-1:0] f_valC,
    input  logic [WORD-1:0] f_valP,
    input  logic            D_stall,
    input  logic            D_bubble,
    input  logic            E_bubble,
    output logic [3:0]      d_srcA,
    output logic [3:0]      d_srcB,
    input  logic [WORD-1:0] rf_valA,
    input  logic [WORD-1:0] rf_valB,
    input  logic [3:0]      e_dstE,
    input  logic [WORD-1:0] e_valE,
    input  logic [3:0]      M_dstE,
    input  logic [WORD-1:0] M_valE,
    input  logic [3:0]      M_dstM,
    input  logic [WORD-1:0] m_valM,
    input  logic [3:0]      W_dstE,
    input  logic [WORD-1:0] W_valE,
    input  logic [3:0]      W_dstM,
    input  logic [WORD-1:0] W_valM,
    output logic [3:0]      D_icode,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [WORD-1:0] E_valC,
    output logic [WORD-1:0] E_valA,
    output logic [WORD-1:0] E_valB,
    output logic [3:0]      E_dstE,
    output logic [3:0]      E_dstM,
    output logic [3:0]      E_srcA,
    output logic [3:0]      E_srcB
);

    d_reg_t          d_q;
    e_reg_t          e_q;
    logic [3:0]      d_dstE;
    logic [3:0]      d_dstM;
    logic [WORD-1:0] d_valA;
    logic [WORD-1:0] d_valB;

    // Stall takes precedence over bubble so a held instruction is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= D_BUBBLE;
        end else if (!D_stall) begin
            if (D_bubble)
                d_q <= D_BUBBLE;
            else
                d_q <= '{icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                         valc: f_valC, valp: f_valP};
        end
    end

    always_comb begin
        d_srcA = NOREG;
        d_srcB = NOREG;
        d_dstE = NOREG;
        d_dstM = NOREG;
        case (d_q.icode)
            I_RRMOVL: begin
                d_srcA = d_q.ra;
                d_dstE = d_q.rb;
            end
            I_IRMOVL: begin
                d_dstE = d_q.rb;
            end
            I_RMMOVL: begin
                d_srcA = d_q.ra;
                d_srcB = d_q.rb;
            end
            I_MRMOVL: begin
                d_srcB = d_q.rb;
                d_dstM = d_q.ra;
            end
            I_OPL: begin
                d_srcA = d_q.ra;
                d_srcB = d_q.rb;
                d_dstE = d_q.rb;
            end
            I_CALL: begin
                d_srcB = ESP;
                d_dstE = ESP;
            end
            I_RET: begin
                d_srcA = ESP;
                d_srcB = ESP;
                d_dstE = ESP;
            end
            I_PUSHL: begin
                d_srcA = d_q.ra;
                d_srcB = ESP;
                d_dstE = ESP;
            end
            I_POPL: begin
                d_srcA = ESP;
                d_srcB = ESP;
                d_dstE = ESP;
                d_dstM = d_q.ra;
            end
            default: begin
            end
        endcase
    end

    fwd_select u_fwd_a (
        .src      (d_srcA),
        .use_valp (uses_valp(d_q.icode)),
        .valp     (d_q.valp),
        .e_dstE   (e_dstE),
        .e_valE   (e_valE),
        .M_dstM   (M_dstM),
        .m_valM   (m_valM),
        .M_dstE   (M_dstE),
        .M_valE   (M_valE),
        .W_dstM   (W_dstM),
        .W_valM   (W_valM),
        .W_dstE   (W_dstE),
        .W_valE   (W_valE),
        .rf_val   (rf_valA),
        .val      (d_valA)
    );

    fwd_select u_fwd_b (
        .src      (d_srcB),
        .use_valp (1'b0),
        .valp     ('0),
        .e_dstE   (e_dstE),
        .e_valE   (e_valE),
        .M_dstM   (M_dstM),
        .m_valM   (m_valM),
        .M_dstE   (M_dstE),
        .M_valE   (M_valE),
        .W_dstM   (W_dstM),
        .W_valM   (W_valM),
        .W_dstE   (W_dstE),
        .W_valE   (W_valE),
        .rf_val   (rf_valB),
        .val      (d_valB)
    );

    // E keeps advancing while D is stalled; the hazard unit bubbles it when needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= E_BUBBLE;
        end else if (E_bubble) begin
            e_q <= E_BUBBLE;
        end else begin
            e_q <= '{icode: d_q.icode, ifun: d_q.ifun, valc: d_q.valc,
                     vala: d_valA, valb: d_valB,
                     dste: d_dstE, dstm: d_dstM, srca: d_srcA, srcb: d_srcB};
        end
    end

    assign D_icode = d_q.icode;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.valc;
    assign E_valA  = e_q.vala;
    assign E_valB  = e_q.valb;
    assign E_dstE  = e_q.dste;
    assign E_dstM  = e_q.dstm;
    assign E_srcA  = e_q.srca;
    assign E_srcB  = e_q.srcb;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - bench for decode_stage against a table-driven reference model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [31:0] f_valC, f_valP;
    logic        D_stall, D_bubble, E_bubble;
    logic [3:0]  d_srcA, d_srcB;
    logic [31:0] rf_valA, rf_valB;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [31:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  D_icode, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [31:0] E_valC, E_valA, E_valB;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .rf_valA(rf_valA), .rf_valB(rf_valB),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .D_icode(D_icode),
        .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [31:0] valc, valp;
    } m_d_t;

    typedef struct {
        logic [3:0]  icode, ifun, dste, dstm, srca, srcb;
        logic [31:0] valc, vala, valb;
    } m_e_t;

    // Register-role table per icode: 0 none, 1 rA, 2 rB, 3 stack pointer
    int src_a_tbl [16] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 3, 1, 3, 0, 0, 0, 0};
    int src_b_tbl [16] = '{0, 0, 0, 0, 2, 2, 2, 0, 3, 3, 3, 3, 0, 0, 0, 0};
    int dst_e_tbl [16] = '{0, 0, 2, 2, 0, 0, 2, 0, 3, 3, 3, 3, 0, 0, 0, 0};
    int dst_m_tbl [16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    m_d_t dm;
    m_e_t em;

    function automatic m_d_t d_bub();
        m_d_t b;
        b.icode = 4'h1; b.ifun = 4'h0; b.ra = 4'hF; b.rb = 4'hF; b.valc = 0; b.valp = 0;
        return b;
    endfunction

    function automatic m_e_t e_bub();
        m_e_t b;
        b.icode = 4'h1; b.ifun = 4'h0; b.dste = 4'hF; b.dstm = 4'hF;
        b.srca = 4'hF; b.srcb = 4'hF; b.valc = 0; b.vala = 0; b.valb = 0;
        return b;
    endfunction

    function automatic logic [3:0] role(int sel, m_d_t d);
        if (sel == 1) return d.ra;
        if (sel == 2) return d.rb;
        if (sel == 3) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [31:0] operand(logic [3:0] src, logic [31:0] rf);
        logic [3:0]  ids  [5];
        logic [31:0] vals [5];
        ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == 4'hF) return 32'h0;
        foreach (ids[i]) if (ids[i] == src) return vals[i];
        return rf;
    endfunction

    function automatic m_e_t decode_model(m_d_t d);
        m_e_t e;
        e.icode = d.icode;
        e.ifun  = d.ifun;
        e.valc  = d.valc;
        e.srca  = role(src_a_tbl[d.icode], d);
        e.srcb  = role(src_b_tbl[d.icode], d);
        e.dste  = role(dst_e_tbl[d.icode], d);
        e.dstm  = role(dst_m_tbl[d.icode], d);
        e.vala  = (d.icode == 4'h8 || d.icode == 4'h7) ? d.valp : operand(e.srca, rf_valA);
        e.valb  = operand(e.srcb, rf_valB);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".D_icode"}, {28'h0, D_icode}, {28'h0, dm.icode});
        chk({tag, ".E_icode"}, {28'h0, E_icode}, {28'h0, em.icode});
        chk({tag, ".E_ifun"},  {28'h0, E_ifun},  {28'h0, em.ifun});
        chk({tag, ".E_valC"},  E_valC, em.valc);
        chk({tag, ".E_valA"},  E_valA, em.vala);
        chk({tag, ".E_valB"},  E_valB, em.valb);
        chk({tag, ".E_dstE"},  {28'h0, E_dstE}, {28'h0, em.dste});
        chk({tag, ".E_dstM"},  {28'h0, E_dstM}, {28'h0, em.dstm});
        chk({tag, ".E_srcA"},  {28'h0, E_srcA}, {28'h0, em.srca});
        chk({tag, ".E_srcB"},  {28'h0, E_srcB}, {28'h0, em.srcb});
    endtask

    task automatic idle_inputs();
        f_icode = 4'h1; f_ifun = 0; f_rA = 4'hF; f_rB = 4'hF; f_valC = 0; f_valP = 0;
        D_stall = 0; D_bubble = 0; E_bubble = 0;
        rf_valA = 0; rf_valB = 0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [31:0] vc, input logic [31:0] vp);
        f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge
    task automatic step(input string tag);
        m_e_t ne;
        m_d_t nd;
        m_e_t pe;
        pe = decode_model(dm);
        #1;
        chk({tag, ".d_srcA"}, {28'h0, d_srcA}, {28'h0, pe.srca});
        chk({tag, ".d_srcB"}, {28'h0, d_srcB}, {28'h0, pe.srcb});
        ne = E_bubble ? e_bub() : pe;
        if (D_stall)
            nd = dm;
        else if (D_bubble)
            nd = d_bub();
        else begin
            nd.icode = f_icode; nd.ifun = f_ifun; nd.ra = f_rA; nd.rb = f_rB;
            nd.valc = f_valC; nd.valp = f_valP;
        end
        @(posedge clk);
        #1;
        em = ne;
        dm = nd;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        dm = d_bub();
        em = e_bub();
        rst = 1'b1;
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // NOP flows through to E after two edges
        fetch(4'h1, 0, 4'hF, 4'hF, 0, 0);
        step("nop1");
        step("nop2");
        chk("nop.E_icode", {28'h0, E_icode}, 32'h1);
        chk("nop.E_dstE", {28'h0, E_dstE}, 32'hF);

        // OPL with register-file operands
        fetch(4'h6, 4'h0, 4'h2, 4'h3, 0, 0);
        step("opl_f");
        fetch(4'h1, 0, 4'hF, 4'hF, 0, 0);
        rf_valA = 32'd5; rf_valB = 32'd7;
        step("opl_e");
        chk("opl.E_valA", E_valA, 32'd5);
        chk("opl.E_valB", E_valB, 32'd7);
        chk("opl.E_dstE", {28'h0, E_dstE}, 32'h3);
        chk("opl.E_dstM", {28'h0, E_dstM}, 32'hF);

        // Execute-stage forward beats memory forward
        fetch(4'h6, 4'h0, 4'h2, 4'h3, 0, 0);
        step("fwd_f");
        fetch(4'h1, 0, 4'hF, 4'hF, 0, 0);
        e_dstE = 4'h2; e_valE = 32'hAA; M_dstM = 4'h2; m_valM = 32'hBB;
        step("fwd_e");
        chk("fwd.E_valA", E_valA, 32'hAA);
        idle_inputs();

        // CALL then POPL
        fetch(4'h8, 4'h0, 4'hF, 4'hF, 32'h100, 32'h40);
        step("call_f");
        fetch(4'hB, 4'h0, 4'h1, 4'hF, 0, 32'h44);
        step("call_e");
        chk("call.E_valA", E_valA, 32'h40);
        chk("call.E_srcB", {28'h0, E_srcB}, 32'h4);
        chk("call.E_dstE", {28'h0, E_dstE}, 32'h4);
        fetch(4'h1, 0, 4'hF, 4'hF, 0, 0);
        step("popl_e");
        chk("popl.E_srcA", {28'h0, E_srcA}, 32'h4);
        chk("popl.E_srcB", {28'h0, E_srcB}, 32'h4);
        chk("popl.E_dstE", {28'h0, E_dstE}, 32'h4);
        chk("popl.E_dstM", {28'h0, E_dstM}, 32'h1);

        // Load-use stall: one NOP in E, MRMOVL follows unchanged
        fetch(4'h5, 4'h0, 4'h6, 4'h3, 32'h1234, 32'h50);
        step("mr_f");
        fetch(4'h6, 4'h0, 4'h6, 4'h2, 0, 32'h52);
        D_stall = 1; E_bubble = 1;
        step("mr_stall");
        chk("stall.E_icode", {28'h0, E_icode}, 32'h1);
        chk("stall.D_icode", {28'h0, D_icode}, 32'h5);
        D_stall = 0; E_bubble = 0;
        fetch(4'h1, 0, 4'hF, 4'hF, 0, 0);
        step("mr_e");
        chk("mr.E_icode", {28'h0, E_icode}, 32'h5);
        chk("mr.E_valC", E_valC, 32'h1234);
        chk("mr.E_dstM", {28'h0, E_dstM}, 32'h6);

        // Asynchronous reset during a stall
        fetch(4'h3, 4'h0, 4'hF, 4'h5, 32'h77, 32'h60);
        step("ir_f");
        step("ir_e");
        D_stall = 1;
        #2;
        rst = 1'b1;
        #1;
        dm = d_bub();
        em = e_bub();
        check_all("async_rst");
        @(negedge clk);
        check_all("rst_held");
        rst = 1'b0;
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            fetch($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom, $urandom);
            D_stall  = ($urandom_range(0, 7) == 0);
            D_bubble = ($urandom_range(0, 7) == 0);
            E_bubble = ($urandom_range(0, 7) == 0);
            rf_valA = $urandom; rf_valB = $urandom;
            e_dstE = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            M_dstE = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            M_dstM = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            W_dstE = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            W_dstM = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            e_valE = $urandom; M_valE = $urandom; m_valM = $urandom;
            W_valE = $urandom; W_valM = $urandom;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
